// File: rtl/sketch_counter_feeder_if.sv
// ---------------------------------------------------------------------------
// sketch_counter_feeder_if
// Purpose : bundles the insert port, the dump request and the valid/ready
//           counter stream of sketch_counter_feeder.
// Signals : Ins_valid/Ins_idx/Ins_weight/Ins_ready - weighted insert request
//           Dump_start                           - start streaming all counters
//           Out_valid/Out_ready/Counter/Out_idx/Out_last - counter stream
//           Done                                 - end-of-dump pulse
//           Idx_err                              - sticky bad-index flag
// Modports: slave  - the feeder itself
//           master - the block driving inserts and consuming the stream
// ---------------------------------------------------------------------------
interface sketch_counter_feeder_if #(
  parameter int CNT_WIDTH = 32,
  parameter int IDX_WIDTH = 4,
  parameter int WGT_WIDTH = 16
);
  logic                 Ins_valid;
  logic [IDX_WIDTH-1:0] Ins_idx;
  logic [WGT_WIDTH-1:0] Ins_weight;
  logic                 Ins_ready;
  logic                 Dump_start;
  logic                 Out_valid;
  logic                 Out_ready;
  logic [CNT_WIDTH-1:0] Counter;
  logic [IDX_WIDTH-1:0] Out_idx;
  logic                 Out_last;
  logic                 Done;
  logic                 Idx_err;

  modport slave (
    input  Ins_valid, Ins_idx, Ins_weight, Dump_start, Out_ready,
    output Ins_ready, Out_valid, Counter, Out_idx, Out_last, Done, Idx_err
  );

  modport master (
    output Ins_valid, Ins_idx, Ins_weight, Dump_start, Out_ready,
    input  Ins_ready, Out_valid, Counter, Out_idx, Out_last, Done, Idx_err
  );
endinterface

// File: rtl/sketch_counter_feeder.sv
// ---------------------------------------------------------------------------
// sketch_counter_feeder
// Purpose : holds NUM_COUNTER sketch counters, accumulates saturating weighted
//           inserts while idle, and on Dump_start streams every counter in
//           index order (one per accepted beat) over a valid/ready link.
// Ports   : Clk     - system clock, rising edge
//           Reset_n - asynchronous active-low reset
//           bus     - sketch_counter_feeder_if.slave (insert, dump, stream)
// Macro   : CLEAR_ON_DUMP_EN - when defined, each counter is zeroed on the
//           edge where its beat handshakes; otherwise counters are retained.
// ---------------------------------------------------------------------------
module sketch_counter_feeder #(
  parameter int NUM_COUNTER = 10,
  parameter int CNT_WIDTH   = 32,
  parameter int IDX_WIDTH   = 4,
  parameter int WGT_WIDTH   = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  sketch_counter_feeder_if.slave  bus
);

  localparam logic [0:0]           ST_IDLE  = 1'b0;
  localparam logic [0:0]           ST_DUMP  = 1'b1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COUNTER - 1);

  logic [0:0]           r_state;
  logic                 r_ins_ready;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_counter;
  logic [IDX_WIDTH-1:0] r_out_idx;
  logic                 r_out_last;
  logic                 r_done;
  logic                 r_idx_err;

  logic [NUM_COUNTER-1:0][CNT_WIDTH-1:0] w_cnt;
  logic [31:0]          w_idx_ext;
  logic                 w_idx_ok;
  logic                 w_ins_fire;
  logic                 w_ins_write;
  logic                 w_handshake;
  logic [CNT_WIDTH-1:0] w_sel_cnt;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_sat;
  logic [IDX_WIDTH-1:0] w_next_idx;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic [CNT_WIDTH-1:0] w_first_cnt;

  // Ins_ready is only ever high in IDLE, so it doubles as the accept gate.
  assign w_idx_ext   = 32'(bus.Ins_idx);
  assign w_idx_ok    = (w_idx_ext < 32'(NUM_COUNTER));
  assign w_ins_fire  = r_ins_ready && bus.Ins_valid;
  assign w_ins_write = w_ins_fire && w_idx_ok;
  assign w_handshake = r_out_valid && bus.Out_ready;
  assign w_next_idx  = r_out_idx + 1'b1;

  // Shared read muxes: the counter addressed by the insert, and the counter
  // that follows the current beat.
  always_comb begin
    w_sel_cnt  = '0;
    w_next_cnt = '0;
    for (int k = 0; k < NUM_COUNTER; k++) begin
      if (bus.Ins_idx == IDX_WIDTH'(k)) w_sel_cnt = w_cnt[k];
      if (w_next_idx == IDX_WIDTH'(k))  w_next_cnt = w_cnt[k];
    end
  end

  // Saturating add: the carry out of the widened sum selects all-ones.
  assign w_sum = {1'b0, w_sel_cnt} + (CNT_WIDTH+1)'(bus.Ins_weight);
  assign w_sat = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];

  // First beat must already include an insert landing on counter 0 in the
  // same cycle as Dump_start.
  assign w_first_cnt = (w_ins_write && (bus.Ins_idx == '0)) ? w_sat : w_cnt[0];

  generate
    for (genvar gi = 0; gi < NUM_COUNTER; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_cnt <= '0;
        end else if (w_ins_write && (bus.Ins_idx == IDX_WIDTH'(gi))) begin
          r_cnt <= w_sat;
`ifdef CLEAR_ON_DUMP_EN
        end else if (w_handshake && (r_out_idx == IDX_WIDTH'(gi))) begin
          r_cnt <= '0;
`endif
        end
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_ins_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_counter   <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_idx_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ins_fire && !w_idx_ok) r_idx_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (bus.Dump_start) begin
            r_state     <= ST_DUMP;
            r_ins_ready <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_idx   <= '0;
            r_counter   <= w_first_cnt;
            r_out_last  <= (LAST_IDX == '0);
          end else begin
            r_ins_ready <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (w_handshake) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_ins_ready <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_out_idx  <= w_next_idx;
              r_counter  <= w_next_cnt;
              r_out_last <= (w_next_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Ins_ready = r_ins_ready;
  assign bus.Out_valid = r_out_valid;
  assign bus.Counter   = r_counter;
  assign bus.Out_idx   = r_out_idx;
  assign bus.Out_last  = r_out_last;
  assign bus.Done      = r_done;
  assign bus.Idx_err   = r_idx_err;

endmodule

// File: tb/tb_sketch_counter_feeder.sv
// ---------------------------------------------------------------------------
// tb_sketch_counter_feeder
// Directed bench for sketch_counter_feeder: reset values, accumulation,
// dump framing and timing, back-pressure, same-cycle insert, bad index,
// mid-dump reset and saturation (on a narrow-counter instance).
// Honours CLEAR_ON_DUMP_EN for the expected values of repeated dumps.
// ---------------------------------------------------------------------------
module tb_sketch_counter_feeder;
  localparam int N = 10;
  typedef logic [31:0] vec_t [N];

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  sketch_counter_feeder_if #(.CNT_WIDTH(32), .IDX_WIDTH(4), .WGT_WIDTH(16)) bus ();
  sketch_counter_feeder_if #(.CNT_WIDTH(20), .IDX_WIDTH(4), .WGT_WIDTH(16)) bus_s ();

  sketch_counter_feeder #(.NUM_COUNTER(N), .CNT_WIDTH(32), .IDX_WIDTH(4), .WGT_WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );
  sketch_counter_feeder #(.NUM_COUNTER(N), .CNT_WIDTH(20), .IDX_WIDTH(4), .WGT_WIDTH(16)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ins(input int idx, input int wgt);
    bus.Ins_valid  = 1'b1;
    bus.Ins_idx    = 4'(idx);
    bus.Ins_weight = 16'(wgt);
    tick();
    bus.Ins_valid  = 1'b0;
    $display("[TB] insert idx=%0d wgt=0x%0h", idx, wgt);
  endtask

  // mode 0: Out_ready always 1; mode 1: Out_ready pattern 1,0,0 repeating.
  task automatic dump(input string name, input vec_t exp, input int mode,
                      input bit same_ins, input int sidx, input int swgt,
                      input bit check_len);
    int beats = 0;
    int cyc   = 0;
    int c     = 0;
    bit rdy_bad = 1'b0;
    bit stall_bad = 1'b0;
    bit stalled = 1'b0;
    logic [3:0]  h_idx = '0;
    logic [31:0] h_cnt = '0;
    bus.Dump_start = 1'b1;
    if (same_ins) begin
      bus.Ins_valid  = 1'b1;
      bus.Ins_idx    = 4'(sidx);
      bus.Ins_weight = 16'(swgt);
    end
    tick();
    cyc = 1;
    bus.Dump_start = 1'b0;
    bus.Ins_valid  = 1'b0;
    check_eq({name, "_valid_first"}, bus.Out_valid, 1);
    while (!bus.Done && cyc < 200) begin
      if (stalled) begin
        if (bus.Out_idx !== h_idx || bus.Counter !== h_cnt || bus.Out_valid !== 1'b1) stall_bad = 1'b1;
        stalled = 1'b0;
      end
      if (bus.Ins_ready !== 1'b0) rdy_bad = 1'b1;
      bus.Out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      c++;
      if (bus.Out_valid === 1'b1) begin
        if (bus.Out_ready) begin
          $display("[TB] %s beat idx=%0d cnt=0x%0h last=%0b", name, bus.Out_idx, bus.Counter, bus.Out_last);
          check_eq($sformatf("%s_idx%0d", name, beats), bus.Out_idx, beats);
          check_eq($sformatf("%s_cnt%0d", name, beats), bus.Counter, (beats < N) ? exp[beats] : 32'hDEAD_BEEF);
          check_eq($sformatf("%s_last%0d", name, beats), bus.Out_last, beats == N - 1);
          beats++;
        end else begin
          stalled = 1'b1;
          h_idx = bus.Out_idx;
          h_cnt = bus.Counter;
        end
      end
      tick();
      cyc++;
    end
    bus.Out_ready = 1'b0;
    check_eq({name, "_done"}, bus.Done, 1);
    check_eq({name, "_beats"}, beats, N);
    check_eq({name, "_valid_after"}, bus.Out_valid, 0);
    check_eq({name, "_insrdy_at_done"}, bus.Ins_ready, 1);
    check_eq({name, "_insrdy_low_in_dump"}, rdy_bad, 0);
    check_eq({name, "_stall_stable"}, stall_bad, 0);
    if (check_len) check_eq({name, "_cycles"}, cyc, N + 1);
    tick();
    check_eq({name, "_done_pulse"}, bus.Done, 0);
  endtask

  vec_t e1, e2, e3, ez;

  initial begin
    e1 = '{0, 0, 12, 0, 0, 0, 0, 0, 0, 1};
    e2 = '{0, 3, 12, 0, 0, 0, 0, 0, 0, 1};
    ez = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef CLEAR_ON_DUMP_EN
    e2 = '{0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    e3 = ez;
`else
    e3 = e2;
`endif
    bus.Ins_valid = 1'b0; bus.Ins_idx = '0; bus.Ins_weight = '0;
    bus.Dump_start = 1'b0; bus.Out_ready = 1'b0;
    bus_s.Ins_valid = 1'b0; bus_s.Ins_idx = '0; bus_s.Ins_weight = '0;
    bus_s.Dump_start = 1'b0; bus_s.Out_ready = 1'b0;
    Reset_n = 1'b0;

    // Reset values
    #12;
    check_eq("rst_ins_ready", bus.Ins_ready, 0);
    check_eq("rst_out_valid", bus.Out_valid, 0);
    check_eq("rst_counter",   bus.Counter, 0);
    check_eq("rst_out_idx",   bus.Out_idx, 0);
    check_eq("rst_out_last",  bus.Out_last, 0);
    check_eq("rst_done",      bus.Done, 0);
    check_eq("rst_idx_err",   bus.Idx_err, 0);
    #10;
    Reset_n = 1'b1;
    tick();
    check_eq("idle_ins_ready", bus.Ins_ready, 1);

    // Basic accumulation and full-rate dump
    ins(2, 5);
    ins(2, 7);
    ins(9, 1);
    dump("d1", e1, 0, 1'b0, 0, 0, 1'b1);

    // Insert in the same cycle as Dump_start is included
    dump("d2", e2, 0, 1'b1, 1, 3, 1'b1);

    // Back-to-back dump with back-pressure
    dump("d3", e3, 1, 1'b0, 0, 0, 1'b0);

    // Out-of-range index: sticky error, no counter touched
    ins(12, 9);
    check_eq("idx_err_set", bus.Idx_err, 1);
    dump("d4", e3, 0, 1'b0, 0, 0, 1'b0);
    check_eq("idx_err_held", bus.Idx_err, 1);

    // Reset in the middle of a dump
    ins(5, 4);
    bus.Dump_start = 1'b1;
    tick();
    bus.Dump_start = 1'b0;
    bus.Out_ready  = 1'b1;
    for (int i = 0; i < 20 && bus.Out_idx !== 4'd4; i++) tick();
    check_eq("mid_reached_beat4", bus.Out_idx, 4);
    #2;
    Reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid",   bus.Out_valid, 0);
    check_eq("mid_rst_done",    bus.Done, 0);
    check_eq("mid_rst_insrdy",  bus.Ins_ready, 0);
    check_eq("mid_rst_idx",     bus.Out_idx, 0);
    check_eq("mid_rst_counter", bus.Counter, 0);
    check_eq("mid_rst_idx_err", bus.Idx_err, 0);
    bus.Out_ready = 1'b0;
    #3;
    Reset_n = 1'b1;
    tick();
    tick();
    check_eq("mid_no_done", bus.Done, 0);
    dump("d5", ez, 0, 1'b0, 0, 0, 1'b1);

    // Saturation on a 20-bit counter instance: 16 x 0xFFFF = 0xFFFF0
    for (int i = 0; i < 16; i++) begin
      bus_s.Ins_valid = 1'b1; bus_s.Ins_idx = 4'd0; bus_s.Ins_weight = 16'hFFFF;
      tick();
      bus_s.Ins_idx = 4'd3;
      tick();
    end
    bus_s.Ins_idx = 4'd0; bus_s.Ins_weight = 16'h0020;  // overflows -> saturate
    tick();
    bus_s.Ins_idx = 4'd3; bus_s.Ins_weight = 16'h000F;  // lands exactly on max
    tick();
    bus_s.Ins_valid = 1'b0;
    $display("[TB] sat preload done");
    bus_s.Dump_start = 1'b1;
    tick();
    bus_s.Dump_start = 1'b0;
    bus_s.Out_ready  = 1'b1;
    for (int b = 0; b < N; b++) begin
      $display("[TB] sat beat idx=%0d cnt=0x%0h", bus_s.Out_idx, bus_s.Counter);
      check_eq($sformatf("sat_idx%0d", b), bus_s.Out_idx, b);
      check_eq($sformatf("sat_cnt%0d", b), bus_s.Counter, (b == 0 || b == 3) ? 20'hFFFFF : 20'h0);
      tick();
    end
    check_eq("sat_done", bus_s.Done, 1);
    bus_s.Out_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
